// File: rtl/aes_pkg.sv
// Shared AES definitions: word/block types, key-schedule FSM states, round
// constants and the forward S-box table used by both key schedule and cipher.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;
    typedef logic [3:0]   rk_idx_t;

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_EXPAND,
        KS_DONE
    } ks_state_t;

    localparam int NR_AES128 = 10;

    // Padded to the full 4-bit index range so any counter value has a defined entry.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox.sv
// Single combinational AES forward S-box lookup.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] result
);

    assign result = SBOX[value];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry
// store, streamed out as produced and readable through a registered port.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128,
    parameter int KW = 128
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] key,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic          rk_valid,
    output rk_idx_t       rk_idx,
    output logic [KW-1:0] rk_stream,
    input  rk_idx_t       rk_sel,
    output logic [KW-1:0] rk_out
);

    localparam rk_idx_t LAST_IDX = rk_idx_t'(NR);

    ks_state_t state;
    ks_state_t next_state;
    rk_idx_t   counter;
    block_t    store [0:NR];
    logic      load;
    logic      step;

    word_t  w0, w1, w2, w3;
    word_t  rot_word;
    word_t  sub_word;
    word_t  t;
    block_t next_key;
    block_t rd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= KS_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            KS_IDLE, KS_DONE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = KS_EXPAND;
                end
            end
            KS_EXPAND: begin
                step = 1'b1;
                if (counter == LAST_IDX) begin
                    next_state = KS_DONE;
                end
            end
            default: next_state = KS_IDLE;
        endcase
    end

    assign ready = (state != KS_EXPAND);
    assign busy  = ~ready;
    assign done  = (state == KS_DONE);

    // rk_stream always holds the last key written, i.e. store[counter-1].
    assign w0       = rk_stream[127:96];
    assign w1       = rk_stream[95:64];
    assign w2       = rk_stream[63:32];
    assign w3       = rk_stream[31:0];
    assign rot_word = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .value  (rot_word[8*g +: 8]),
            .result (sub_word[8*g +: 8])
        );
    end

    always_comb begin
        t        = sub_word ^ {RCON[counter], 24'h0};
        next_key = '0;
        next_key[127:96] = w0 ^ t;
        next_key[95:64]  = w1 ^ next_key[127:96];
        next_key[63:32]  = w2 ^ next_key[95:64];
        next_key[31:0]   = w3 ^ next_key[63:32];
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i <= NR; i++) begin
            if (rk_sel == rk_idx_t'(i)) begin
                rd_data = store[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rk_valid  <= 1'b0;
            rk_idx    <= '0;
            rk_stream <= '0;
            rk_out    <= '0;
            counter   <= '0;
            for (int i = 0; i <= NR; i++) begin
                store[i] <= '0;
            end
        end else begin
            rk_out   <= rd_data;
            rk_valid <= load | step;
            if (load) begin
                store[0]  <= key;
                rk_stream <= key;
                rk_idx    <= '0;
                counter   <= rk_idx_t'(1);
            end else if (step) begin
                for (int i = 1; i <= NR; i++) begin
                    if (counter == rk_idx_t'(i)) begin
                        store[i] <= next_key;
                    end
                end
                rk_stream <= next_key;
                rk_idx    <= counter;
                counter   <= counter + rk_idx_t'(1);
            end
        end
    end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
Iterative AES-128 key schedule that sits directly upstream of the newkey encryption core and supplies its round keys. On a start pulse it latches a 128-bit cipher key, then generates round keys 1..10, one per clock, into an internal 11-entry round-key store. The store is read through a registered indexed port, and each key is also streamed out as it is produced, so the core can consume keys on the fly or after completion.

Parameters:
NR, 10, number of rounds; AES-128 only, other values unsupported.
KW, 128, key and round-key width in bits.

Ports:
clk  in  1  system clock; all state on rising edge.
rst  in  1  asynchronous, active-low reset; 0 clears all state immediately.
start  in  1  single-cycle request to expand key; honoured only when ready=1.
key  in  128  cipher key, FIPS-197 byte order (byte 0 = bits 127:120); sampled on the accepted start edge only.
ready  out  1  1 = idle or done, able to accept start.
busy  out  1  1 = expansion in progress; always the inverse of ready.
done  out  1  1 = store holds a complete schedule for the last accepted key.
rk_valid  out  1  1-cycle strobe: rk_stream/rk_idx carry a newly written round key.
rk_idx  out  4  index 0..10 of rk_stream.
rk_stream  out  128  round key just written.
rk_sel  in  4  read index for the store.
rk_out  out  128  store[rk_sel], registered, 1-cycle latency; 0 if rk_sel > 10.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; ready=1, busy=0, done=0, rk_valid=0, rk_idx=0, rk_stream=0, rk_out=0; all 11 store entries=0; round counter=0.
- FSM states IDLE, EXPAND, DONE.
- IDLE or DONE with start=1: store[0]<=key; rk_stream<=key, rk_idx<=0, rk_valid<=1; counter<=1; done<=0; go to EXPAND. The next edge sees busy=1.
- EXPAND: each cycle compute round key i=counter from store[i-1]:
  - t = SubWord(RotWord(w3)) XOR {Rcon[i],24'h0}, with w0..w3 the 32-bit words of store[i-1], w0 = bits 127:96.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
  - Write store[i], pulse rk_valid with rk_idx=i, then counter++.
  - After writing i=10: go to DONE, done<=1.
- Latency: start accepted at edge T0; key k appears on rk_stream at edge T0+k, for k = 0..10. done=1 and ready=1 from T0+10.
- start while busy: ignored, with no effect on counter or store. key changes during EXPAND: ignored, because the key is latched.
- DONE with start: restarts expansion. Store entries 1..10 keep stale values until overwritten; done=0 marks them invalid.
- rk_out is updated every cycle regardless of state. A read of the entry being written in the same cycle returns the old value.
- rst asserted mid-EXPAND: immediate return to reset state, with partial results discarded.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- SubWord uses four parallel combinational S-box lookups. There is exactly one round computation per cycle; no unrolling.

Decomposition:
- Package aes_pkg holds:
  - typedefs: word_t (32 bits), block_t (128 bits), rk_idx_t (4 bits).
  - constant NR_AES128=10.
  - RCON array.
  - S-box constant table, shared with the encryption core.
- Sub-module aes_sbox: combinational 8-bit in, 8-bit out, table lookup from aes_pkg; four instances here.
- FSM, counter and store live in aes_key_expand itself.

Test Plan:
1. Reset check: hold rst=0 then release -> ready=1, busy=0, done=0, rk_valid=0, rk_out=0 for every rk_sel.
2. FIPS-197 key expansion with key=2b7e151628aed2a6abf7158809cf4f3c:
   - start -> stream idx1=a0fafe1788542cb123a339392a6c7605, idx2=f2c295f27a96b9435935807a7359f67f, idx10=d014f9a8c9ee2589e13f0cc8b6630ca6.
   - done rises exactly 10 cycles after the start edge.
3. Store readback after test 2: rk_sel=0..10 -> rk_out equals the streamed values one cycle after each rk_sel change; rk_sel=15 -> 0.
4. start pulsed and key changed mid-expansion (cycle 4) -> ignored; final keys are identical to test 2, and busy stays 1 until done.
5. Reset mid-operation: rst=0 at cycle 5 -> all outputs 0 immediately. A fresh start with key=000102030405060708090a0b0c0d0e0f gives idx10=13111d7fe3944a17f307a78b4d2b30c5.
6. Back-to-back: start in the DONE cycle with a new key -> done drops on the next edge and rk_valid strobes continue without a gap, idx0..10.
